// File: rtl/alu_issue_if.sv
// alu_issue_if: request/response valid-ready bundle between a requester and alu_issue_ctrl
interface alu_issue_if #(parameter int TAG_W = 4);
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_a;
    logic [31:0]      req_b;
    logic [2:0]       req_op;
    logic [TAG_W-1:0] req_tag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [3:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
    modport master (
        output req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
    );
    modport slave (
        input  req_valid, req_a, req_b, req_op, req_tag, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_tag
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: queues ALU requests, drives the ALU from registers and returns tagged results with NZCV flags
module alu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic        clk,
    input  logic        reset,
    alu_issue_if.slave  bus,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_opcode,
    input  logic [31:0] alu_result,
    input  logic        alu_carry,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    output logic [3:0]  flags_q,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, RESPOND} state_t;
    state_t           state_q, state_d;
    logic [31:0]      mem_a [DEPTH];
    logic [31:0]      mem_b [DEPTH];
    logic [2:0]       mem_op [DEPTH];
    logic [TAG_W-1:0] mem_tag [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      result_q;
    logic             push, pop, arith;
    logic [3:0]       flags_d;
    logic [1:0]       unused_flags;
    assign unused_flags   = {alu_zero, alu_negative};
    assign bus.req_ready  = count < (AW+1)'(DEPTH);
    assign push           = bus.req_valid && bus.req_ready;
    assign bus.rsp_valid  = state_q == RESPOND;
    assign bus.rsp_result = result_q;
    assign bus.rsp_flags  = flags_q;
    assign bus.rsp_tag    = tag_q;
    assign busy           = state_q != IDLE || count != 0;
    always_comb begin
        pop     = count != 0 && (state_q == IDLE || (state_q == RESPOND && bus.rsp_ready));
        state_d = pop ? ISSUE : state_q == ISSUE ? RESPOND : state_q == RESPOND && bus.rsp_ready ? IDLE : state_q;
        arith   = alu_opcode[2:1] == 2'b00;
        flags_d = {alu_result[31], alu_result == 32'd0,
                   arith ? alu_carry : flags_q[1], arith ? alu_overflow : flags_q[0]};
    end
    always_ff @(posedge clk) state_q <= reset ? IDLE : state_d;
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            tag_q      <= '0;
            result_q   <= '0;
            flags_q    <= '0;
        end else begin
            if (push) begin
                mem_a[wr_ptr]   <= bus.req_a;
                mem_b[wr_ptr]   <= bus.req_b;
                mem_op[wr_ptr]  <= bus.req_op;
                mem_tag[wr_ptr] <= bus.req_tag;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            if (pop) begin
                alu_a      <= mem_a[rd_ptr];
                alu_b      <= mem_b[rd_ptr];
                alu_opcode <= mem_op[rd_ptr];
                tag_q      <= mem_tag[rd_ptr];
                rd_ptr     <= rd_ptr + 1'b1;
            end
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (state_q == ISSUE) begin
                result_q <= alu_result;
                flags_q  <= flags_d;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed stimulus with a response scoreboard for alu_issue_ctrl
module tb_alu_issue_ctrl;
    localparam int DEPTH = 4;
    typedef struct {logic [31:0] r; logic [3:0] f; logic [3:0] t;} exp_t;
    logic        clk = 0;
    logic        reset = 1;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [2:0]  alu_opcode;
    logic        alu_carry, alu_zero, alu_negative, alu_overflow;
    logic [3:0]  flags_q;
    logic        busy;
    exp_t        sb[$];
    int          checks = 0, passed = 0, cyc = 0, prev_cyc = 0;
    logic        tp_mode = 0, have_prev = 0;
    alu_issue_if #(.TAG_W(4)) bus ();
    alu_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_negative(alu_negative), .alu_overflow(alu_overflow),
        .flags_q(flags_q), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    // Reference ALU; logical ops report junk C/V so preservation errors show up
    always_comb begin
        logic [32:0] s;
        s = '0;
        alu_carry = 0;
        alu_overflow = 0;
        alu_result = 0;
        case (alu_opcode)
            3'd0: begin
                s = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = s[31:0];
                alu_carry = s[32];
                alu_overflow = alu_a[31] == alu_b[31] && s[31] != alu_a[31];
            end
            3'd1: begin
                alu_result = alu_a - alu_b;
                alu_carry = alu_a >= alu_b;
                alu_overflow = alu_a[31] != alu_b[31] && alu_result[31] != alu_a[31];
            end
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_b >= 32 ? 0 : alu_a << alu_b[4:0];
            3'd4: alu_result = alu_b >= 32 ? 0 : alu_a >> alu_b[4:0];
            default: alu_result = 0;
        endcase
        if (alu_opcode[2:1] != 2'b00) begin
            alu_carry = ~alu_result[0];
            alu_overflow = 1;
        end
        alu_zero = alu_result == 0;
        alu_negative = alu_result[31];
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else passed++;
    endtask
    always @(negedge clk) begin
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL unexpected_rsp: tag %0d result 0x%08h with empty scoreboard", bus.rsp_tag, bus.rsp_result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_result", bus.rsp_result, e.r);
                chk("rsp_flags", 32'(bus.rsp_flags), 32'(e.f));
                chk("rsp_tag", 32'(bus.rsp_tag), 32'(e.t));
                chk("flags_q", 32'(flags_q), 32'(e.f));
            end
            if (tp_mode) begin
                if (have_prev) chk("rsp_spacing", 32'(cyc - prev_cyc), 2);
                prev_cyc = cyc;
                have_prev = 1;
            end
        end
    end
    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                        input logic [3:0] tag, input logic exp, input logic [31:0] er, input logic [3:0] ef);
        int n;
        exp_t e;
        if (exp) begin
            e.r = er; e.f = ef; e.t = tag;
            sb.push_back(e);
        end
        bus.req_valid = 1;
        bus.req_a = a;
        bus.req_b = b;
        bus.req_op = op;
        bus.req_tag = tag;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL push_timeout: tag %0d never accepted", tag);
        end
        @(posedge clk); #1;
        bus.req_valid = 0;
    endtask
    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            $display("FAIL drain_timeout: busy %0b pending %0d", busy, sb.size());
        end
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        bus.req_valid = 0;
        bus.req_a = 0;
        bus.req_b = 0;
        bus.req_op = 0;
        bus.req_tag = 0;
        bus.rsp_ready = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        chk("rst_req_ready", 32'(bus.req_ready), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_flags", 32'(bus.rsp_flags), 0);
        chk("rst_rsp_tag", 32'(bus.rsp_tag), 0);
        chk("rst_flags_q", 32'(flags_q), 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_opcode", 32'(alu_opcode), 0);
        chk("rst_busy", 32'(busy), 0);
        push(32'hFFFF_FFFF, 1, 3'd0, 4'd3, 1, 0, 4'b0110);
        chk("lat_t1_valid", 32'(bus.rsp_valid), 0);
        @(posedge clk); #1;
        chk("lat_t2_valid", 32'(bus.rsp_valid), 0);
        chk("lat_t2_busy", 32'(busy), 1);
        @(posedge clk); #1;
        chk("lat_t3_valid", 32'(bus.rsp_valid), 1);
        chk("lat_t3_flags_q", 32'(flags_q), 32'b0110);
        wait_idle();
        push(32'h8000_0000, 32'hFFFF_FFFF, 3'd2, 4'd5, 1, 32'h8000_0000, 4'b1010);
        push(32'h8000_0000, 1, 3'd1, 4'd6, 1, 32'h7FFF_FFFF, 4'b0011);
        push(5, 7, 3'd7, 4'd7, 1, 0, 4'b0111);
        push(1, 33, 3'd3, 4'd1, 1, 0, 4'b0111);
        push(3, 4, 3'd3, 4'd2, 1, 32'h30, 4'b0011);
        push(32'h8000_0000, 31, 3'd4, 4'd4, 1, 1, 4'b0011);
        push(32'h7FFF_FFFF, 1, 3'd0, 4'd9, 1, 32'h8000_0000, 4'b1001);
        wait_idle();
        bus.rsp_ready = 0;
        for (int i = 0; i <= DEPTH; i++) push(i, 10, 3'd0, 4'(8 + i), 1, 32'(i + 10), 4'b0000);
        chk("full_req_ready", 32'(bus.req_ready), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("stall_rsp_valid", 32'(bus.rsp_valid), 1);
        chk("stall_req_ready", 32'(bus.req_ready), 0);
        chk("stall_rsp_tag", 32'(bus.rsp_tag), 8);
        tp_mode = 1;
        have_prev = 0;
        bus.rsp_ready = 1;
        @(posedge clk); #1;
        chk("refill_req_ready", 32'(bus.req_ready), 1);
        wait_idle();
        tp_mode = 0;
        push(32'hFFFF_FFFF, 1, 3'd0, 4'd13, 1, 0, 4'b0110);
        push(1, 2, 3'd0, 4'd14, 0, 0, 0);
        push(3, 4, 3'd1, 4'd15, 0, 0, 0);
        push(5, 6, 3'd2, 4'd0, 0, 0, 0);
        chk("pre_rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("pre_rst_busy", 32'(busy), 1);
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_flags_q", 32'(flags_q), 0);
        chk("mid_rst_req_ready", 32'(bus.req_ready), 1);
        chk("mid_rst_rsp_result", bus.rsp_result, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_busy", 32'(busy), 0);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
